fmul_norm_round: RTL

//  Downstream stage of the 12-bit Karatsuba mantissa multiplier in the float MAC datapath.
//  - Consumes the 24-bit mantissa product plus operand signs and exponents.
//  - Normalizes, rounds to nearest-even, adds the exponents and range-checks the result.
//  - Emits a packed float {sign, exp, frac} through a 2-stage valid/ready pipeline.

---
 rtl/fmul_norm_round.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fmul_norm_round.sv
// fmul_norm_round: normalizes, rounds (nearest-even) and range-checks the
// Karatsuba mantissa product, emitting a packed {sign, exp, frac} float
// through a two-entry valid/ready pipeline.
module fmul_norm_round #(
  parameter int EXP_W  = 6,
  parameter int FRAC_W = 11,
  parameter int BIAS   = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*FRAC_W+1:0]     prod,
  input  logic                    sa,
  input  logic                    sb,
  input  logic [EXP_W-1:0]        ea,
  input  logic [EXP_W-1:0]        eb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_f,
  output logic                    ovf,
  output logic                    unf
);

  localparam int PW = 2*FRAC_W + 2;  // product width
  localparam int SW = EXP_W + 2;     // stage-1 signed exponent width
  localparam int EW = EXP_W + 3;     // post-normalize exponent width, headroom for +2
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic          s1_valid;
  logic          s1_sign;
  logic          s1_zero;
  logic [SW-1:0] s1_exp;
  logic [PW-1:0] s1_prod;
  logic          s1_adv;

  logic [FRAC_W-1:0] nm, rm;
  logic              ng, ns, rup, carry;
  logic [EW-1:0]     ne, re;

  logic [EXP_W+FRAC_W:0] r_f;
  logic                  r_ovf, r_unf;

  // Output register frees up when empty or being drained; stage 1 can take a
  // new entry when empty or when its contents move on this cycle.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  // Stage 1: capture sign, unbiased-sum exponent, zero flag and raw product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_sign <= sa ^ sb;
        s1_exp  <= SW'(ea) + SW'(eb) - SW'(BIAS);
        s1_zero <= (ea == '0) || (eb == '0);
        s1_prod <= prod;
      end
    end
  end

  // Normalize on the product MSB, then round to nearest-even with carry-out
  // into the exponent (exponent kept sign-extended for the range checks).
  always_comb begin
    nm = '0;
    ng = 1'b0;
    ns = 1'b0;
    ne = {s1_exp[SW-1], s1_exp};
    if (s1_prod[PW-1]) begin
      nm = s1_prod[PW-2 -: FRAC_W];
      ng = s1_prod[FRAC_W];
      ns = |s1_prod[FRAC_W-1:0];
      ne = {s1_exp[SW-1], s1_exp} + EW'(1);
    end else begin
      nm = s1_prod[PW-3 -: FRAC_W];
      ng = s1_prod[FRAC_W-1];
      ns = |s1_prod[FRAC_W-2:0];
    end
    rup = ng && (ns || nm[0]);
    {carry, rm} = {1'b0, nm} + (FRAC_W+1)'(rup);
    re = ne + EW'(carry);
  end

  // Result select: zero operand, then overflow to infinity, then flush to zero.
  always_comb begin
    r_f   = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
    r_ovf = 1'b0;
    r_unf = 1'b0;
    if (s1_zero) begin
      r_f = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (!re[EW-1] && (re >= EMAX)) begin
      r_f   = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      r_ovf = 1'b1;
    end else if (re[EW-1] || (re == '0)) begin
      r_unf = 1'b1;
    end else begin
      r_f = {s1_sign, re[EXP_W-1:0], rm};
    end
  end

  // Stage 2: output register, holds while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_f <= r_f;
        ovf   <= r_ovf;
        unf   <= r_unf;
      end
    end
  end

endmodule
